rca_sweep_driver: RTL and testbench

Synthesizable stimulus-and-check stage placed directly upstream of the `rca` ripple-carry adder. It feeds the adder's `a_i`/`b_i` inputs with every operand pair, one at a time, and reads back its `sum_o`. Each sampled sum is compared against a reference sum and mismatches are counted. It replaces the file-dump sweep with an on-chip, clocked self-check that reports pass/fail and the first failing pair.

---
 rtl/rca_sweep_driver_pkg.sv | 20 ++
 rtl/rca_sweep_driver_if.sv | 11 +
 rtl/rca_sweep_driver_counter.sv | 24 ++
 rtl/rca_sweep_driver.sv | 129 ++++++++++++
 tb/tb_rca_sweep_driver.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_sweep_driver_pkg.sv
// Shared types and width helpers for the rca sweep driver.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mismatch counter width: holds up to 2^(2*width) without overflow.
  function automatic int unsigned cnt_width(input int unsigned width);
    return 2 * width + 1;
  endfunction

  // Settle counter width for a hold time of 'settle' cycles.
  function automatic int unsigned settle_width(input int unsigned settle);
    return $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/rca_sweep_driver_if.sv
// Operand/result bus between the sweep driver and the adder under test.
interface rca_sweep_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;

  modport master (output a, output b, input sum);
  modport slave  (input a, input b, output sum);
endinterface

// File: rtl/rca_sweep_driver_counter.sv
// Operand-pair counter: {a,b} concatenated, b is the low (inner) half.
module sweep_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  // Up-count on enable; wraps to zero after the terminal count.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

  assign tc_o = &count_o;

endmodule

// File: rtl/rca_sweep_driver.sv
// Exhaustive operand sweep for an rca adder with on-chip result checking.
module rca_sweep_driver
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic [WIDTH-1:0]      a_o,
  output logic [WIDTH-1:0]      b_o,
  input  logic [WIDTH:0]        sum_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [2*WIDTH:0]      err_cnt_o,
  output logic [WIDTH-1:0]      fail_a_o,
  output logic [WIDTH-1:0]      fail_b_o
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned SW = settle_width(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_t              state;
  state_t              state_n;
  logic [SW-1:0]       settle_cnt;
  logic [2*WIDTH-1:0]  pair;
  logic                pair_tc;
  logic                start_ok;
  logic                sample;
  logic                mismatch;
  logic [WIDTH:0]      expected;
  logic [CW-1:0]       err_next;

  sweep_counter #(
    .WIDTH (2 * WIDTH)
  ) u_counter (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (start_ok),
    .en_i    (sample),
    .count_o (pair),
    .tc_o    (pair_tc)
  );

  assign a_o = pair[2*WIDTH-1:WIDTH];
  assign b_o = pair[WIDTH-1:0];

  // Next-state decode; a sample happens on the last settle cycle of each pair.
  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    sample   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_n  = RUN;
          start_ok = 1'b1;
        end
      end
      RUN: begin
        if (settle_cnt == SETTLE_LAST) begin
          sample = 1'b1;
          if (pair_tc) begin
            state_n = DONE;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Reference sum at full width and the resulting mismatch decision.
  always_comb begin
    expected = {1'b0, a_o} + {1'b0, b_o};
    mismatch = sample && (sum_i != expected);
    err_next = err_cnt_o + CW'(mismatch);
  end

  // State register; busy/done registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_n;
      busy_o <= (state_n == RUN);
      done_o <= (state_n == DONE);
    end
  end

  // Settle counter: restarts for every new pair.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || start_ok || sample) begin
      settle_cnt <= '0;
    end else if (state == RUN) begin
      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  // Error bookkeeping; pass is resolved on the final compare so it includes it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_cnt_o <= '0;
      fail_a_o  <= '0;
      fail_b_o  <= '0;
      pass_o    <= 1'b0;
    end else if (start_ok) begin
      err_cnt_o <= '0;
      fail_a_o  <= '0;
      fail_b_o  <= '0;
      pass_o    <= 1'b0;
    end else if (sample) begin
      err_cnt_o <= err_next;
      if (mismatch && (err_cnt_o == '0)) begin
        fail_a_o <= a_o;
        fail_b_o <= b_o;
      end
      if (state_n == DONE) begin
        pass_o <= (err_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_rca_sweep_driver.sv
// Scoreboard bench: a narrow driver (WIDTH=2, SETTLE=1) and a wider one
// (WIDTH=4, SETTLE=3) each drive a behavioural adder through the bus interface.
module tb_rca_sweep_driver;

  typedef struct {
    int a;
    int b;
  } pair_t;

  typedef struct {
    int pass;
    int err;
    int fa;
    int fb;
    int len;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start2 = 1'b0;
  logic start4 = 1'b0;
  logic fault = 1'b0;

  int total = 0;
  int bad = 0;

  pair_t q_pair2[$];
  res_t  q_res2[$];
  pair_t q_pair4[$];
  res_t  q_res4[$];

  always #5 clk = ~clk;

  rca_sweep_driver_if #(.WIDTH(2)) bus2 ();
  rca_sweep_driver_if #(.WIDTH(4)) bus4 ();

  logic       busy2, done2, pass2;
  logic [4:0] err2;
  logic [1:0] fa2, fb2;
  logic       busy4, done4, pass4;
  logic [8:0] err4;
  logic [3:0] fa4, fb4;

  // Behavioural adders; the fault forces sum bit 1 stuck at 0.
  assign bus2.sum = fault ? (({1'b0, bus2.a} + {1'b0, bus2.b}) & 3'b101)
                          : ({1'b0, bus2.a} + {1'b0, bus2.b});
  assign bus4.sum = {1'b0, bus4.a} + {1'b0, bus4.b};

  rca_sweep_driver #(
    .WIDTH  (2),
    .SETTLE (1)
  ) u_dut2 (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start2),
    .a_o       (bus2.a),
    .b_o       (bus2.b),
    .sum_i     (bus2.sum),
    .busy_o    (busy2),
    .done_o    (done2),
    .pass_o    (pass2),
    .err_cnt_o (err2),
    .fail_a_o  (fa2),
    .fail_b_o  (fb2)
  );

  rca_sweep_driver #(
    .WIDTH  (4),
    .SETTLE (3)
  ) u_dut4 (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start4),
    .a_o       (bus4.a),
    .b_o       (bus4.b),
    .sum_i     (bus4.sum),
    .busy_o    (busy4),
    .done_o    (done4),
    .pass_o    (pass4),
    .err_cnt_o (err4),
    .fail_a_o  (fa4),
    .fail_b_o  (fb4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Narrow monitor: each busy cycle presents one pair; done presents a result.
  int run2 = 0;
  always @(negedge clk) begin
    pair_t p;
    res_t  r;
    if (busy2) begin
      run2++;
      if (q_pair2.size() == 0) begin
        check("busy2_unexpected", 64'd1, 64'd0);
      end else begin
        p = q_pair2.pop_front();
        check("pair2_a", 64'(bus2.a), 64'(p.a));
        check("pair2_b", 64'(bus2.b), 64'(p.b));
      end
    end
    if (done2) begin
      if (q_res2.size() == 0) begin
        check("done2_unexpected", 64'd1, 64'd0);
      end else begin
        r = q_res2.pop_front();
        check("res2_pass", 64'(pass2), 64'(r.pass));
        check("res2_err", 64'(err2), 64'(r.err));
        check("res2_fail_a", 64'(fa2), 64'(r.fa));
        check("res2_fail_b", 64'(fb2), 64'(r.fb));
        check("res2_len", 64'(run2), 64'(r.len));
        check("res2_busy_low", 64'(busy2), 64'd0);
      end
      run2 = 0;
    end
    if (!busy2 && !done2) run2 = 0;
  end

  // Wide monitor: also checks the carry-out sums seen on the bus.
  int run4 = 0;
  always @(negedge clk) begin
    pair_t p;
    res_t  r;
    if (busy4) begin
      run4++;
      if (q_pair4.size() == 0) begin
        check("busy4_unexpected", 64'd1, 64'd0);
      end else begin
        p = q_pair4.pop_front();
        check("pair4_a", 64'(bus4.a), 64'(p.a));
        check("pair4_b", 64'(bus4.b), 64'(p.b));
      end
      if (bus4.a == 4'd15 && bus4.b == 4'd15) check("carry4_15_15", 64'(bus4.sum), 64'd30);
      if (bus4.a == 4'd8 && bus4.b == 4'd8)   check("carry4_8_8", 64'(bus4.sum), 64'd16);
    end
    if (done4) begin
      if (q_res4.size() == 0) begin
        check("done4_unexpected", 64'd1, 64'd0);
      end else begin
        r = q_res4.pop_front();
        check("res4_pass", 64'(pass4), 64'(r.pass));
        check("res4_err", 64'(err4), 64'(r.err));
        check("res4_len", 64'(run4), 64'(r.len));
      end
      run4 = 0;
    end
    if (!busy4 && !done4) run4 = 0;
  end

  task automatic push_pairs2(input int n);
    for (int i = 0; i < n; i++) q_pair2.push_back('{a: i / 4, b: i % 4});
  endtask

  task automatic push_res2(input int pass, input int err, input int fa, input int fb);
    q_res2.push_back('{pass: pass, err: err, fa: fa, fb: fb, len: 16});
  endtask

  task automatic idle_check2(input string tag);
    check({tag, "_busy"}, 64'(busy2), 64'd0);
    check({tag, "_done"}, 64'(done2), 64'd0);
    check({tag, "_pass"}, 64'(pass2), 64'd0);
    check({tag, "_err"}, 64'(err2), 64'd0);
    check({tag, "_fa"}, 64'(fa2), 64'd0);
    check({tag, "_fb"}, 64'(fb2), 64'd0);
    check({tag, "_a"}, 64'(bus2.a), 64'd0);
    check({tag, "_b"}, 64'(bus2.b), 64'd0);
  endtask

  // Pulse start at a falling edge, then count falling edges until done is
  // seen; the count spans the start edge through the done cycle.
  task automatic run_sweep2(input string tag, output int n);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done2) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    int n;

    // Reset held for two cycles, then idle with no start.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    idle_check2("reset");
    check("reset_busy4", 64'(busy4), 64'd0);
    check("reset_err4", 64'(err4), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    idle_check2("nostart");

    // Golden sweep.
    push_pairs2(16);
    push_res2(1, 0, 0, 0);
    run_sweep2("golden", n);
    check("golden_latency", 64'(n), 64'd17);
    repeat (3) @(negedge clk);
    check("golden_pass_held", 64'(pass2), 64'd1);

    // Sum bit 1 stuck at 0: sums 2,3,6 fail -> 3+4+1 = 8, first at (0,2).
    fault = 1'b1;
    push_pairs2(16);
    push_res2(0, 8, 0, 2);
    run_sweep2("fault", n);
    repeat (2) @(negedge clk);
    fault = 1'b0;

    // Reset after the seventh RUN cycle.
    push_pairs2(7);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    idle_check2("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    idle_check2("midreset_after");
    push_pairs2(16);
    push_res2(1, 0, 0, 0);
    run_sweep2("restart", n);
    repeat (2) @(negedge clk);

    // Start pulses at RUN cycle 5 and in the DONE cycle are ignored.
    push_pairs2(16);
    push_res2(1, 0, 0, 0);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (4) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 6;
    while (!done2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done2) check("ignore_timeout", 64'd1, 64'd0);
    check("ignore_latency", 64'(n), 64'd17);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("ignore_no_restart", 64'(busy2), 64'd0);
    end

    // Wide sweep: 256 pairs, each held for 3 cycles.
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 3; k++) q_pair4.push_back('{a: i / 16, b: i % 16});
    end
    q_res4.push_back('{pass: 1, err: 0, fa: 0, fb: 0, len: 768});
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (!done4) check("wide_timeout", 64'd1, 64'd0);
    check("wide_latency", 64'(n), 64'd769);
    repeat (3) @(negedge clk);

    check("drain_pair2", 64'(q_pair2.size()), 64'd0);
    check("drain_res2", 64'(q_res2.size()), 64'd0);
    check("drain_pair4", 64'(q_pair4.size()), 64'd0);
    check("drain_res4", 64'(q_res4.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
